// File: rtl/rot16_stream.sv
// rot16_stream: handshaked 16-bit rotate stage with a 2-entry request FIFO,
// a registered result slot and a completed-handshake counter.
module rot16_stream #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [3:0]  in_amt,
  input  logic        in_dir,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [15:0] op_count
);

  // Only DEPTH = 2 is supported; pointers and count are sized for it.
  localparam logic [1:0] FULL_COUNT = DEPTH[1:0];

  logic [15:0] fifo_data_q [2];
  logic [3:0]  fifo_amt_q  [2];
  logic        fifo_dir_q  [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;

  logic        out_valid_q, out_valid_d;
  logic [15:0] out_data_q, out_data_d;
  logic [15:0] op_count_q, op_count_d;

  logic        push;
  logic        pop;
  logic        fifo_empty;

  logic [15:0] head_data;
  logic [3:0]  head_amt;
  logic        head_dir;
  logic [3:0]  left_amt;
  logic [15:0] rot_s0, rot_s1, rot_s2, rot_s3;

  assign fifo_empty = (count_q == 2'd0);
  assign in_ready   = (count_q != FULL_COUNT);
  assign push       = in_valid && in_ready;
  assign pop        = !fifo_empty && (!out_valid_q || out_ready);

  assign head_data  = fifo_data_q[rd_ptr_q];
  assign head_amt   = fifo_amt_q[rd_ptr_q];
  assign head_dir   = fifo_dir_q[rd_ptr_q];

  // A right rotate by k is a left rotate by (16 - k) mod 16, so one
  // four-stage left barrel rotator serves both directions.
  always_comb begin
    left_amt = head_dir ? (4'd0 - head_amt) : head_amt;
    rot_s0   = left_amt[0] ? {head_data[14:0], head_data[15]}  : head_data;
    rot_s1   = left_amt[1] ? {rot_s0[13:0],    rot_s0[15:14]}  : rot_s0;
    rot_s2   = left_amt[2] ? {rot_s1[11:0],    rot_s1[15:12]}  : rot_s1;
    rot_s3   = left_amt[3] ? {rot_s2[7:0],     rot_s2[15:8]}   : rot_s2;
  end

  always_comb begin
    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = rot_s3;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign op_count_d = (out_valid_q && out_ready) ? op_count_q + 16'd1 : op_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
      op_count_q  <= 16'h0000;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      op_count_q  <= op_count_d;
    end
  end

  // Entry storage is only meaningful while counted, but is cleared so the
  // head never presents X to the rotator after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= 16'h0000;
        fifo_amt_q[i]  <= 4'd0;
        fifo_dir_q[i]  <= 1'b0;
      end
    end else if (push) begin
      fifo_data_q[wr_ptr_q] <= in_data;
      fifo_amt_q[wr_ptr_q]  <= in_amt;
      fifo_dir_q[wr_ptr_q]  <= in_dir;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_rot16_stream.sv
// Directed bench for rot16_stream: reset, rotates, left/right equivalence,
// back-pressure, mid-stream reset and op_count wrap.
`timescale 1ns/1ps
module tb_rot16_stream;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_amt;
  logic        in_dir;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [15:0] op_count;

  int checks;
  int failures;
  int exp_count;

  // 0xA5C3 rotated left by k, worked out by hand.
  logic [15:0] a5c3_left [16] = '{
    16'hA5C3, 16'h4B87, 16'h970E, 16'h2E1D, 16'h5C3A, 16'hB874, 16'h70E9, 16'hE1D2,
    16'hC3A5, 16'h874B, 16'h0E97, 16'h1D2E, 16'h3A5C, 16'h74B8, 16'hE970, 16'hD2E1
  };

  rot16_stream #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_dir    (in_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'($urandom);
      in_data   = 16'($urandom);
      in_amt    = 4'($urandom);
      in_dir    = 1'($urandom);
      out_ready = 1'($urandom);
      step();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_hold_valid: got %b want 0", out_valid);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #2 rst_n  = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (out_data !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_out_data: got %h want 0000", out_data);
    end
    checks++;
    if (op_count !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_op_count: got %h want 0000", op_count);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic_rotates();
    logic [15:0] vd [4] = '{16'h8001, 16'h1234, 16'h1234, 16'hBEEF};
    logic [3:0]  va [4] = '{4'd1, 4'd4, 4'd4, 4'd0};
    logic        vr [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] ve [4] = '{16'h0003, 16'h2341, 16'h4123, 16'hBEEF};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL basic_in_ready[%0d]: got %b want 1", i, in_ready);
      end
      in_valid = 1'b1;
      in_data  = vd[i];
      in_amt   = va[i];
      in_dir   = vr[i];
      step();
      in_valid = 1'b0;
      in_data  = 16'hFFFF;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL basic_early_valid[%0d]: got %b want 0", i, out_valid);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== ve[i]) begin
        failures++;
        $display("[TB] FAIL basic_result[%0d]: got valid=%b data=%h want valid=1 data=%h",
                 i, out_valid, out_data, ve[i]);
      end
      step();
      exp_count++;
    end
    checks++;
    if (op_count !== 16'(exp_count)) begin
      failures++;
      $display("[TB] FAIL basic_op_count: got %0d want %0d", op_count, exp_count);
    end
  endtask

  task automatic test_equivalence_sweep();
    logic [3:0]  k;
    logic [3:0]  lk;
    logic [15:0] want;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      k    = 4'(i);
      lk   = 4'd0 - k;
      want = a5c3_left[lk];
      for (int d = 0; d < 2; d++) begin
        in_valid = 1'b1;
        in_data  = 16'hA5C3;
        in_amt   = (d == 0) ? k : lk;
        in_dir   = (d == 0);
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== want) begin
          failures++;
          $display("[TB] FAIL sweep_%s[%0d]: got valid=%b data=%h want valid=1 data=%h",
                   (d == 0) ? "right" : "left", (d == 0) ? k : lk, out_valid, out_data, want);
        end
        step();
        exp_count++;
      end
    end
    checks++;
    if (op_count !== 16'(exp_count)) begin
      failures++;
      $display("[TB] FAIL sweep_op_count: got %0d want %0d", op_count, exp_count);
    end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0001; in_amt = 4'd1; in_dir = 1'b0;
    step();
    in_data   = 16'h00F0; in_amt = 4'd4; in_dir = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0002) begin
      failures++;
      $display("[TB] FAIL bp_first_result: got valid=%b data=%h want valid=1 data=0002", out_valid, out_data);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_ready_before_third: got %b want 1", in_ready);
    end
    in_data   = 16'h8000; in_amt = 4'd1; in_dir = 1'b0;
    step();
    in_data   = 16'h1234; in_amt = 4'd8; in_dir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'h0002) begin
        failures++;
        $display("[TB] FAIL bp_stall[%0d]: got ready=%b valid=%b data=%h want ready=0 valid=1 data=0002",
                 i, in_ready, out_valid, out_data);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_data !== 16'h000F || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_drain2: got data=%h ready=%b want data=000F ready=1", out_data, in_ready);
    end
    step();
    checks++;
    if (out_data !== 16'h0001 || out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_drain3: got valid=%b data=%h want valid=1 data=0001", out_valid, out_data);
    end
    in_data   = 16'hABCD; in_amt = 4'd12; in_dir = 1'b1;
    step();
    in_valid  = 1'b0;
    checks++;
    if (out_data !== 16'h3412) begin
      failures++;
      $display("[TB] FAIL bp_req4: got %h want 3412", out_data);
    end
    step();
    checks++;
    if (out_data !== 16'hBCDA || out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_req5: got valid=%b data=%h want valid=1 data=BCDA", out_valid, out_data);
    end
    step();
    exp_count += 5;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'hBCDA) begin
      failures++;
      $display("[TB] FAIL bp_empty_hold: got valid=%b data=%h want valid=0 data=BCDA", out_valid, out_data);
    end
    checks++;
    if (op_count !== 16'(exp_count)) begin
      failures++;
      $display("[TB] FAIL bp_op_count: got %0d want %0d", op_count, exp_count);
    end
  endtask

  task automatic test_reset_mid_stream();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h1111; in_amt = 4'd1; in_dir = 1'b0;
    step();
    in_data   = 16'h2222;
    step();
    in_data   = 16'h3333;
    step();
    in_valid  = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_prefill: got valid=%b ready=%b want valid=1 ready=0", out_valid, in_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || op_count !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL mid_async_clear: got valid=%b data=%h count=%h want 0/0000/0000",
               out_valid, out_data, op_count);
    end
    step();
    rst_n = 1'b1;
    exp_count = 0;
    step();
    checks++;
    if (in_ready !== 1'b1 || op_count !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL mid_release: got ready=%b count=%h want ready=1 count=0000", in_ready, op_count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 16'h0000) begin
        failures++;
        $display("[TB] FAIL mid_no_old_data[%0d]: got valid=%b data=%h want valid=0 data=0000",
                 i, out_valid, out_data);
      end
    end
  endtask

  task automatic test_counter_wrap();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h5A5A; in_amt = 4'd3; in_dir = 1'b1;
    for (int i = 0; i < 65535; i++) step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (op_count !== 16'hFFFF || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wrap_preload: got count=%h valid=%b want count=FFFF valid=0", op_count, out_valid);
    end
    in_valid = 1'b1;
    in_data  = 16'h0F0F; in_amt = 4'd4; in_dir = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hF0F0 || op_count !== 16'hFFFF) begin
      failures++;
      $display("[TB] FAIL wrap_last: got valid=%b data=%h count=%h want 1/F0F0/FFFF",
               out_valid, out_data, op_count);
    end
    step();
    checks++;
    if (op_count !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL wrap_rollover: got %h want 0000", op_count);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    exp_count = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    in_amt    = 4'd0;
    in_dir    = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic_rotates();
    test_equivalence_sweep();
    test_back_pressure();
    test_reset_mid_stream();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rot16_stream.md
# rot16_stream

Pipelined, handshaked 16-bit rotate stage for streaming datapaths. Accepts rotate requests (operand, 4-bit amount, direction) on a valid/ready input port, buffers them in a 2-entry FIFO, computes the left or right rotation, and holds results in an output register drained through a valid/ready port. It sits between an operand producer and the ALU write-back path, providing back-pressure isolation and a completed-operation count.

## Interface
- `DEPTH`, 2, input FIFO entries (fixed at 2; other values unsupported).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  stage can accept a request this cycle.
- `in_data`  in  16  operand.
- `in_amt`  in  4  rotate amount, 0..15.
- `in_dir`  in  1  0 = rotate left, 1 = rotate right.
- `out_valid`  out  1  result register holds a valid result.
- `out_ready`  in  1  consumer accepts the result this cycle.
- `out_data`  out  16  rotated result.
- `op_count`  out  16  number of completed output handshakes, wraps mod 2^16.

## Operation
- Input handshake: a request is accepted on a rising edge where `in_valid && in_ready`. `in_ready = !fifo_full`, where full means 2 entries. Computed from registered state only, with no combinational path from `out_ready`.
- FIFO: 2 entries of {data, amt, dir}, with read/write pointers and an occupancy count of 0..2. Simultaneous push and pop at count 2 is not possible because `in_ready` is 0. At count 1 or 0, push and pop on the same edge leave the count unchanged or +1 as appropriate.
- Rotation, combinational from the FIFO head:
  - Left by k: `out[i] = d[(i-k) mod 16]`.
  - Right by k: `out[i] = d[(i+k) mod 16]`.
  - k = 0 passes the operand unchanged.
  - Right by k equals left by (16-k) mod 16.
- Output register load: on an edge where FIFO is non-empty and (`!out_valid || out_ready`), the rotated head loads into `out_data`, `out_valid` is set, and the FIFO pops.
- Output register clear: on an edge where `out_valid && out_ready` and the FIFO is empty, `out_valid` clears and `out_data` holds its last value.
- `op_count` increments by 1 on every edge with `out_valid && out_ready`, wrapping from 0xFFFF to 0x0000.
- While `out_valid` is high and `out_ready` is low, `out_data` must stay stable.
- There are no X-propagation dependencies: `in_data`, `in_amt` and `in_dir` are ignored when `in_valid` = 0.

## Timing
- Reset values (asynchronous on `rst_n` low, released synchronously by design): `out_valid`=0, `out_data`=0x0000, `op_count`=0x0000, FIFO count=0, pointers=0, `in_ready`=1 on the first cycle after reset.
- Latency: a request accepted at edge N into an empty stage produces `out_valid`=1 with the result after edge N+1 (2-cycle accept-to-visible).
- Throughput: 1 result per cycle sustained while `out_ready`=1.
- Capacity: 3 outstanding requests (2 in the FIFO + 1 in the output register). A 4th request stalls with `in_ready`=0.
- Once the output register frees, `in_ready` rises on the cycle after the edge that pops the FIFO.
- Reset asserted mid-operation discards all buffered requests and the held result immediately. No partial handshake completes, and `op_count` returns to 0.

## Test plan
- Reset/idle: with `rst_n` low, drive random inputs; then release. Required: `out_valid`=0, `out_data`=0x0000, `op_count`=0, `in_ready`=1.
- Basic rotates: with `out_ready`=1, issue four requests:
  - 0x8001 left 1 → 0x0003.
  - 0x1234 left 4 → 0x2341.
  - 0x1234 right 4 → 0x4123.
  - 0xBEEF amt 0 either direction → 0xBEEF.
  
  Each appears 2 cycles after acceptance, in order, and `op_count` ends at 4.
- Equivalence sweep: for 0xA5C3 and all k in 0..15, right k equals left (16-k) mod 16. Example: right 1 → 0xD2E1, left 15 → 0xD2E1.
- Back-pressure: hold `out_ready`=0 and offer 5 back-to-back requests.
  - `in_ready` drops after the 3rd accept.
  - `out_data` stays stable at the 1st result.
  - Raising `out_ready` drains results 1-3 in order on consecutive cycles.
  - Requests 4-5 are then accepted.
- Counter wrap: preload by running 65535 handshakes (or force in sim), then complete one more. Required: `op_count` transitions from 0xFFFF to 0x0000.
- Reset mid-stream: with 3 requests buffered and `out_ready`=0, pulse `rst_n` low for 1 cycle. Required: `out_valid`=0 immediately, and after release `in_ready`=1 with `op_count`=0. Old data never appears at the output.
